// File: rtl/serial_deframer_if.sv
// Serial deframer bus: serial line in, recovered word plus status strobes out.
// Optional macro: SERIAL_DEFRAMER_PARITY_EN adds the parity_err strobe.
interface serial_deframer_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             busy;
  logic             frame_err;
`ifdef SERIAL_DEFRAMER_PARITY_EN
  logic             parity_err;

  // Source side: drives the serial line, observes the recovered words
  modport master (
    output data_in,
    input  data_out, valid, busy, frame_err, parity_err
  );

  // Deframer side
  modport slave (
    input  data_in,
    output data_out, valid, busy, frame_err, parity_err
  );
`else
  // Source side: drives the serial line, observes the recovered words
  modport master (
    output data_in,
    input  data_out, valid, busy, frame_err
  );

  // Deframer side
  modport slave (
    input  data_in,
    output data_out, valid, busy, frame_err
  );
`endif
endinterface

// File: rtl/serial_deframer.sv
// Serial-to-parallel frame receiver.
// Frame: start bit (1), WIDTH data bits LSB first, [even parity bit], stop bit (0).
// Optional macro: SERIAL_DEFRAMER_PARITY_EN adds the parity state and parity_err.
module serial_deframer #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  serial_deframer_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SERIAL_DEFRAMER_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
`ifdef SERIAL_DEFRAMER_PARITY_EN
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
`endif

  // Next-state and next-output computation for the frame receiver
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = busy_q;
`ifdef SERIAL_DEFRAMER_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.data_in) begin
          state_d = DATA;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef SERIAL_DEFRAMER_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end

      DATA: begin
        // Right shift so the first (LSB) bit received lands in bit 0
        shift_d = {bus.data_in, shift_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
`ifdef SERIAL_DEFRAMER_PARITY_EN
        par_d   = par_q ^ bus.data_in;
        if (cnt_q == LAST_BIT) state_d = PARITY;
`else
        if (cnt_q == LAST_BIT) state_d = STOP;
`endif
      end

`ifdef SERIAL_DEFRAMER_PARITY_EN
      PARITY: begin
        par_d   = par_q ^ bus.data_in;
        state_d = STOP;
      end
`endif

      STOP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (bus.data_in) begin
          // Bad stop bit wins over any parity problem
          frame_err_d = 1'b1;
`ifdef SERIAL_DEFRAMER_PARITY_EN
        end else if (par_q) begin
          parity_err_d = 1'b1;
`endif
        end else begin
          data_out_d = shift_q;
          valid_d    = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
`ifdef SERIAL_DEFRAMER_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
`ifdef SERIAL_DEFRAMER_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_deframer.sv
// Directed bench for serial_deframer (WIDTH=8); parity checks compile in with
// SERIAL_DEFRAMER_PARITY_EN.
module tb_serial_deframer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_deframer_if #(.WIDTH(W)) bus ();

  serial_deframer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         stop;
    logic         exp_valid;
    logic         exp_ferr;
    logic [W-1:0] exp_dout;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one bit, let the DUT sample it, settle 1ns after the edge
  task automatic send_bit(input logic b);
    bus.data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_out(input string tag, input logic [W-1:0] dout);
    chk({tag, " valid"}, 32'(bus.valid), 32'd0);
    chk({tag, " frame_err"}, 32'(bus.frame_err), 32'd0);
    chk({tag, " data_out"}, 32'(bus.data_out), 32'(dout));
`ifdef SERIAL_DEFRAMER_PARITY_EN
    chk({tag, " parity_err"}, 32'(bus.parity_err), 32'd0);
`endif
  endtask

  // Start, data LSB first, [parity], stop; checks busy and quiet strobes mid-frame
  task automatic send_frame(input string tag, input logic [W-1:0] data,
                            input logic par, input logic stop,
                            input logic [W-1:0] prev_dout);
    send_bit(1'b1);
    chk({tag, " busy@start"}, 32'(bus.busy), 32'd1);
    check_idle_out({tag, " @start"}, prev_dout);
    for (int unsigned i = 0; i < W; i++) begin
      send_bit(data[i]);
      chk($sformatf("%s busy@bit%0d", tag, i), 32'(bus.busy), 32'd1);
      chk($sformatf("%s valid@bit%0d", tag, i), 32'(bus.valid), 32'd0);
    end
`ifdef SERIAL_DEFRAMER_PARITY_EN
    send_bit(par);
    chk({tag, " busy@par"}, 32'(bus.busy), 32'd1);
`else
    if (par) begin end
`endif
    send_bit(stop);
    chk({tag, " busy@stop"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b0, exp_valid: 1'b1, exp_ferr: 1'b0, exp_dout: 8'hA5};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b1, exp_ferr: 1'b0, exp_dout: 8'h3C};
    vecs[2] = '{data: 8'hFF, stop: 1'b0, exp_valid: 1'b1, exp_ferr: 1'b0, exp_dout: 8'hFF};
    vecs[3] = '{data: 8'h12, stop: 1'b1, exp_valid: 1'b0, exp_ferr: 1'b1, exp_dout: 8'hFF};
    vecs[4] = '{data: 8'h00, stop: 1'b0, exp_valid: 1'b1, exp_ferr: 1'b0, exp_dout: 8'h00};
    vecs[5] = '{data: 8'h80, stop: 1'b0, exp_valid: 1'b1, exp_ferr: 1'b0, exp_dout: 8'h80};
    vecs[6] = '{data: 8'h01, stop: 1'b0, exp_valid: 1'b1, exp_ferr: 1'b0, exp_dout: 8'h01};

    // Reset with the line held high: must not start a frame
    reset = 1'b1;
    bus.data_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    check_idle_out("reset", 8'h00);

    reset = 1'b0;
    for (int unsigned c = 0; c < 10; c++) begin
      send_bit(1'b0);
      chk($sformatf("idle%0d busy", c), 32'(bus.busy), 32'd0);
      check_idle_out($sformatf("idle%0d", c), 8'h00);
    end

    // Table frames back to back, no idle gap; frame 4 follows a frame error
    begin
      logic [W-1:0] prev = 8'h00;
      for (int unsigned i = 0; i < 7; i++) begin
        string t;
        t = $sformatf("vec%0d", i);
        send_frame(t, vecs[i].data, ^vecs[i].data, vecs[i].stop, prev);
        chk({t, " valid"}, 32'(bus.valid), 32'(vecs[i].exp_valid));
        chk({t, " frame_err"}, 32'(bus.frame_err), 32'(vecs[i].exp_ferr));
        chk({t, " data_out"}, 32'(bus.data_out), 32'(vecs[i].exp_dout));
        prev = vecs[i].exp_dout;
      end
    end

    // Strobes are one cycle wide and data_out holds
    send_bit(1'b0);
    chk("hold busy", 32'(bus.busy), 32'd0);
    check_idle_out("hold", 8'h01);
    send_bit(1'b0);
    check_idle_out("hold2", 8'h01);

    // Reset after 4 data bits of 0x55 aborts silently
    send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    reset = 1'b1;
    send_bit(1'b0);
    chk("midrst busy", 32'(bus.busy), 32'd0);
    check_idle_out("midrst", 8'h00);
    reset = 1'b0;
    for (int unsigned c = 0; c < 6; c++) begin
      send_bit(1'b0);
      check_idle_out($sformatf("postrst%0d", c), 8'h00);
    end
    send_frame("x81", 8'h81, 1'b0, 1'b0, 8'h00);
    chk("x81 valid", 32'(bus.valid), 32'd1);
    chk("x81 frame_err", 32'(bus.frame_err), 32'd0);
    chk("x81 data_out", 32'(bus.data_out), 32'h81);
    send_bit(1'b0);
    check_idle_out("x81 after", 8'h81);

`ifdef SERIAL_DEFRAMER_PARITY_EN
    // 0xA5 has four ones: even parity bit is 0
    send_frame("parok", 8'hA5, 1'b0, 1'b0, 8'h81);
    chk("parok valid", 32'(bus.valid), 32'd1);
    chk("parok parity_err", 32'(bus.parity_err), 32'd0);
    chk("parok data_out", 32'(bus.data_out), 32'hA5);
    send_frame("parbad", 8'h3C, 1'b1, 1'b0, 8'hA5);
    chk("parbad valid", 32'(bus.valid), 32'd0);
    chk("parbad parity_err", 32'(bus.parity_err), 32'd1);
    chk("parbad frame_err", 32'(bus.frame_err), 32'd0);
    chk("parbad data_out", 32'(bus.data_out), 32'hA5);
    send_frame("parbad2", 8'hA5, 1'b1, 1'b0, 8'hA5);
    chk("parbad2 valid", 32'(bus.valid), 32'd0);
    chk("parbad2 parity_err", 32'(bus.parity_err), 32'd1);
    send_frame("both", 8'hA5, 1'b1, 1'b1, 8'hA5);
    chk("both frame_err", 32'(bus.frame_err), 32'd1);
    chk("both parity_err", 32'(bus.parity_err), 32'd0);
    chk("both valid", 32'(bus.valid), 32'd0);
    chk("both data_out", 32'(bus.data_out), 32'hA5);
    send_bit(1'b0);
    check_idle_out("par after", 8'hA5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
